demux_lane_sequencer: RTL

Upstream feeder for the 2-bit 1-to-4 lane demux.
- Accepts one packed 8-bit word per valid/ready transfer.
- Splits the word into four 2-bit symbols.
- Presents one symbol per transfer on a/s, with an out_valid/out_ready handshake, so the demux routes each symbol to its lane (symbol k goes to lane k).
- Signals word completion with a one-cycle done pulse.

---
 rtl/demux_lane_sequencer_pkg.sv | 46 ++++
 rtl/demux_lane_sequencer_if.sv | 50 +++++
 rtl/demux_lane_sequencer_lane_ptr.sv | 87 ++++++++
 rtl/demux_lane_sequencer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/demux_lane_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// demux_seq_pkg
//
// Shared definitions for the demux lane sequencer slice:
//   - geometry localparams (symbol width, lanes per word, word width)
//   - the sequencer FSM state type
//   - next_nonzero(): finds the next lane index above a pointer whose symbol
//     is nonzero. It is used only when DEMUX_SEQ_SKIP_ZERO_EN is defined.
//
// No ports; import with `import demux_seq_pkg::*;`.
// -----------------------------------------------------------------------------
package demux_seq_pkg;

    localparam int SYM_W  = 2;              // symbol width = demux lane width
    localparam int LANES  = 4;              // fixed: the lane select s is 2 bits
    localparam int DATA_W = SYM_W * LANES;  // packed input word width (derived)
    localparam int PTR_W  = 2;              // lane pointer width

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } seq_state_t;

    // Result of a forward search for the next nonzero symbol.
    typedef struct packed {
        logic [PTR_W-1:0] idx;        // index found (holds ptr when none_left)
        logic             none_left;  // no nonzero symbol strictly above ptr
    } nz_result_t;

    // Search lanes strictly above ptr for a nonzero symbol. The loop runs from
    // the top down so the lowest matching index is the one left standing.
    function automatic nz_result_t next_nonzero(input logic [DATA_W-1:0] word,
                                                input logic [PTR_W-1:0]  ptr);
        nz_result_t r;
        r.idx       = ptr;
        r.none_left = 1'b1;
        for (int k = LANES - 1; k >= 0; k--) begin
            if ((k > int'(ptr)) && (word[k*SYM_W +: SYM_W] != '0)) begin
                r.idx       = PTR_W'(k);
                r.none_left = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_lane_sequencer_if.sv
// -----------------------------------------------------------------------------
// demux_lane_sequencer_if
//
// Bundles the two handshakes of the demux lane sequencer plus its status.
//
// Handshake semantics (both the in_* and out_* channels): a transfer happens
// on a rising clk edge where valid and ready are both 1. While valid is high
// and ready is low, the sender holds its payload and valid stable. The sender
// never waits for ready before raising valid. On the output side the
// sequencer is the sender: a/s/out_valid stay frozen through a stall.
//
// Signals:
//   in_data   [DATA_W] packed word; symbol k = in_data[2k+1:2k]
//   in_valid           in_data is valid
//   in_ready           sequencer can take a word this cycle
//   a         [SYM_W]  symbol to the demux data input (00 when idle)
//   s         [PTR_W]  lane select to the demux select input (00 when idle)
//   out_valid          a/s carry a live symbol
//   out_ready          consumer accepts a/s this cycle
//   busy               a word is held
//   done               one-cycle pulse after the last symbol is accepted
//   state_dbg          current FSM state, for observation only
//
// Modports: slave = the sequencer, master = the environment driving it.
// -----------------------------------------------------------------------------
interface demux_lane_sequencer_if;
    import demux_seq_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [SYM_W-1:0]  a;
    logic [PTR_W-1:0]  s;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    seq_state_t        state_dbg;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, a, s, out_valid, busy, done, state_dbg
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, a, s, out_valid, busy, done, state_dbg
    );

endinterface

// File: rtl/demux_lane_sequencer_lane_ptr.sv
// -----------------------------------------------------------------------------
// demux_lane_ptr
//
// Lane pointer for the demux lane sequencer. Holds the 2-bit pointer register
// and decides where it goes on a load or an advance, and whether the symbol
// currently pointed at is the last one of the word.
//
// Build option: DEMUX_SEQ_SKIP_ZERO_EN
//   undefined - pointer loads 0 and steps by one; last when ptr == 3.
//   defined   - pointer loads the first nonzero lane and jumps to the next
//               nonzero lane; last when no nonzero symbol lies above ptr.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load        a new word is being captured this cycle
//   advance     the current symbol was accepted and is not the last
//   load_word   word being captured (skip build only)
//   word        word currently held (skip build only)
//   load_empty  load_word has no nonzero symbol (skip build only)
//   ptr         current lane pointer
//   last        the current symbol is the final one of the word
// -----------------------------------------------------------------------------
module demux_lane_ptr
    import demux_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
`ifdef DEMUX_SEQ_SKIP_ZERO_EN
    input  logic [DATA_W-1:0] load_word,
    input  logic [DATA_W-1:0] word,
    output logic              load_empty,
`endif
    output logic [PTR_W-1:0]  ptr,
    output logic              last
);

    logic [PTR_W-1:0] ptr_q;

`ifdef DEMUX_SEQ_SKIP_ZERO_EN
    nz_result_t first_nz;
    nz_result_t next_nz;

    // next_nonzero() only looks strictly above its pointer, so lane 0 of the
    // incoming word is tested on its own.
    always_comb begin
        if (load_word[SYM_W-1:0] != '0) begin
            first_nz.idx       = '0;
            first_nz.none_left = 1'b0;
        end else begin
            first_nz = next_nonzero(load_word, '0);
        end
    end

    assign next_nz    = next_nonzero(word, ptr_q);
    assign load_empty = first_nz.none_left;
    assign last       = next_nz.none_left;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (load) begin
            ptr_q <= first_nz.idx;
        end else if (advance) begin
            ptr_q <= next_nz.idx;
        end
    end
`else
    assign last = (ptr_q == PTR_W'(LANES - 1));

    // The pointer only wraps from 3 back to 0 through a load; advance is
    // never asserted on the last symbol.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (load) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_q + 1'b1;
        end
    end
`endif

    assign ptr = ptr_q;

endmodule

// File: rtl/demux_lane_sequencer.sv
// -----------------------------------------------------------------------------
// demux_lane_sequencer
//
// Upstream feeder for the 2-bit 1-to-4 lane demux. It takes one packed 8-bit
// word per in_valid/in_ready transfer and splits it into four 2-bit symbols.
// It then presents one symbol per out_valid/out_ready transfer as a (data)
// and s (lane select), so symbol k lands on demux lane k. A one-cycle done
// pulse follows acceptance of a word's last symbol.
//
// A word accepted on an edge appears on a/s from the next cycle. If a new
// word arrives in the same cycle the last symbol is accepted, it is captured
// straight away, so consecutive words stream with no bubble. in_ready has a
// combinational path from out_ready for that case.
//
// Build option: DEMUX_SEQ_SKIP_ZERO_EN (see demux_lane_ptr). When defined,
// 00 symbols are not presented. An all-zero word is accepted, never raises
// out_valid, and pulses done the cycle after capture. If an all-zero word is
// captured as the previous word finishes, both completions share one pulse.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   demux_lane_sequencer_if.slave (handshakes, a/s, busy, done,
//         state_dbg)
// -----------------------------------------------------------------------------
module demux_lane_sequencer
    import demux_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    demux_lane_sequencer_if.slave  bus
);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [DATA_W-1:0] word_q;
    logic              done_q;
    logic              done_d;

    logic              load;
    logic              advance;
    logic              in_ready_c;
    logic              out_valid_c;
    logic [PTR_W-1:0]  ptr;
    logic              last;
`ifdef DEMUX_SEQ_SKIP_ZERO_EN
    logic              load_empty;
`endif

    demux_lane_ptr u_lane_ptr (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .advance    (advance),
`ifdef DEMUX_SEQ_SKIP_ZERO_EN
        .load_word  (bus.in_data),
        .word       (word_q),
        .load_empty (load_empty),
`endif
        .ptr        (ptr),
        .last       (last)
    );

    // State, held word and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load) begin
                word_q <= bus.in_data;
            end
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        advance     = 1'b0;
        done_d      = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end

            SEND: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    if (last) begin
                        // Last symbol leaves now: the slot is free this very
                        // cycle, so a waiting word is taken without a bubble.
                        done_d     = 1'b1;
                        in_ready_c = 1'b1;
                        if (bus.in_valid) begin
                            load    = 1'b1;
                            state_d = SEND;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef DEMUX_SEQ_SKIP_ZERO_EN
        // Nothing to present: complete the word on the capture edge itself.
        if (load && load_empty) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
`endif
    end

    // a/s are forced to 00 whenever no symbol is live so the demux sees an
    // inert input; this also makes them drop immediately on reset.
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.a         = out_valid_c ? word_q[int'(ptr)*SYM_W +: SYM_W] : '0;
    assign bus.s         = out_valid_c ? ptr : '0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;

endmodule
